// File: rtl/cpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_seq_ctrl
//  Description : Multi-cycle instruction sequencer for the RV32I core. Holds
//                the PC and instruction register, runs the instruction memory
//                fetch handshake, and steps each instruction through FETCH,
//                DECODE, EXEC and WB. Also provides halt/resume at instruction
//                boundaries and a retired-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_seq_ctrl #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter int              PC_STEP   = 4,
   parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] instr,
   input  logic            dec_w_enable,
   output logic            rf_rd_enable,
   output logic            rf_w_enable,
   input  logic            halt,
   output logic            halted,
   output logic            retire,
   output logic [XLEN-1:0] pc,
   output logic [31:0]     instret
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_HALTED = 3'd5
   } state_t;

   localparam logic [XLEN-1:0] c_pc_step = XLEN'(PC_STEP);

   state_t          r_state;
   state_t          w_next_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_instr;
   logic [31:0]     r_instret;

   // State register; reset parks the sequencer in IDLE immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode; halt is only honoured at instruction boundaries.
   always_comb begin
      w_next_state = S_IDLE;
      case (r_state)
         S_IDLE:   w_next_state = halt ? S_HALTED : S_FETCH;
         S_FETCH:  w_next_state = imem_ready ? S_DECODE : S_FETCH;
         S_DECODE: w_next_state = S_EXEC;
         S_EXEC:   w_next_state = S_WB;
         S_WB:     w_next_state = halt ? S_HALTED : S_FETCH;
         S_HALTED: w_next_state = halt ? S_HALTED : S_FETCH;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // Architectural registers: instruction capture on fetch accept, PC and
   // retire count advance only when an instruction leaves WB.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc      <= RESET_PC;
         r_instr   <= NOP_INSTR;
         r_instret <= 32'd0;
      end else begin
         if ((r_state == S_FETCH) && imem_ready) begin
            r_instr <= imem_rdata;
         end
         if (r_state == S_WB) begin
            r_pc      <= r_pc + c_pc_step;
            r_instret <= r_instret + 32'd1;
         end
      end
   end

   // Outputs are decoded from registered state; the write strobe is the
   // decoder's enable qualified by WB so each instruction writes at most once.
   assign imem_req     = (r_state == S_FETCH);
   assign imem_addr    = r_pc;
   assign pc           = r_pc;
   assign instr        = r_instr;
   assign instret      = r_instret;
   assign rf_rd_enable = (r_state == S_DECODE) || (r_state == S_EXEC);
   assign retire       = (r_state == S_WB);
   assign rf_w_enable  = (r_state == S_WB) && dec_w_enable;
   assign halted       = (r_state == S_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_cpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_seq_ctrl
//  Description : Self-checking bench for cpu_seq_ctrl: instruction-level
//                reference model compared every cycle, plus directed checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_seq_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        dec_w_enable;
   logic        halt;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] instr;
   logic        rf_rd_enable;
   logic        rf_w_enable;
   logic        halted;
   logic        retire;
   logic [31:0] pc;
   logic [31:0] instret;

   // Second instance for the PC wrap boundary
   logic        reset2;
   logic        imem_req2;
   logic [31:0] imem_addr2;
   logic [31:0] instr2;
   logic        rf_rd_enable2;
   logic        rf_w_enable2;
   logic        halted2;
   logic        retire2;
   logic [31:0] pc2;
   logic [31:0] instret2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   cpu_seq_ctrl dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .instr(instr), .dec_w_enable(dec_w_enable),
      .rf_rd_enable(rf_rd_enable), .rf_w_enable(rf_w_enable),
      .halt(halt), .halted(halted), .retire(retire),
      .pc(pc), .instret(instret)
   );

   cpu_seq_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .reset(reset2),
      .imem_req(imem_req2), .imem_addr(imem_addr2),
      .imem_ready(1'b1), .imem_rdata(32'h0000_0013),
      .instr(instr2), .dec_w_enable(1'b1),
      .rf_rd_enable(rf_rd_enable2), .rf_w_enable(rf_w_enable2),
      .halt(1'b0), .halted(halted2), .retire(retire2),
      .pc(pc2), .instret(instret2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (instruction level) ----------------
   // An instruction is "being fetched" until memory answers, then spends
   // three further cycles (decode, execute, writeback) before it retires.
   bit          m_idle;
   bit          m_fetching;
   bit          m_halted;
   int          m_left;      // cycles left after fetch accept (3..1), 0 = none
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_instret;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_idle     <= 1'b1;
         m_fetching <= 1'b0;
         m_halted   <= 1'b0;
         m_left     <= 0;
         m_pc       <= 32'h0;
         m_instr    <= 32'h0000_0013;
         m_instret  <= 32'h0;
      end else if (m_idle) begin
         m_idle <= 1'b0;
         if (halt) m_halted <= 1'b1;
         else      m_fetching <= 1'b1;
      end else if (m_fetching) begin
         if (imem_ready) begin
            m_instr    <= imem_rdata;
            m_fetching <= 1'b0;
            m_left     <= 3;
         end
      end else if (m_left != 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_pc      <= m_pc + 32'd4;
            m_instret <= m_instret + 32'd1;
            if (halt) m_halted <= 1'b1;
            else      m_fetching <= 1'b1;
         end
      end else if (m_halted) begin
         if (!halt) begin
            m_halted   <= 1'b0;
            m_fetching <= 1'b1;
         end
      end
   end

   // Compare every cycle on the falling edge
   always @(negedge clk) begin
      chk("imem_req",     {31'd0, imem_req},     {31'd0, m_fetching});
      chk("imem_addr",    imem_addr,             m_pc);
      chk("pc",           pc,                    m_pc);
      chk("instr",        instr,                 m_instr);
      chk("instret",      instret,               m_instret);
      chk("rf_rd_enable", {31'd0, rf_rd_enable}, {31'd0, (m_left == 3 || m_left == 2)});
      chk("retire",       {31'd0, retire},       {31'd0, (m_left == 1)});
      chk("rf_w_enable",  {31'd0, rf_w_enable},  {31'd0, (m_left == 1) && dec_w_enable});
      chk("halted",       {31'd0, halted},       {31'd0, m_halted});
   end

   // Advance one clock; inputs change 2 time units after the rising edge
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      reset        = 1'b0;
      reset2       = 1'b0;
      imem_ready   = 1'b1;
      imem_rdata   = 32'h0010_0093;
      dec_w_enable = 1'b1;
      halt         = 1'b0;
      step();
      step();
      chk("rst_pc",      pc, 32'h0);
      chk("rst_instr",   instr, 32'h0000_0013);
      chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
      reset = 1'b1;

      // Back-to-back instructions with zero wait states
      for (int c = 1; c <= 13; c++) begin
         step();
         imem_rdata = 32'h0010_0093 + (c << 20);
         if (c == 1 || c == 5 || c == 9) begin
            chk("t1_req",  {31'd0, imem_req}, 32'd1);
            chk("t1_addr", imem_addr, 32'((c - 1)));
         end
         if (c == 4 || c == 8 || c == 12)
            chk("t1_retire", {31'd0, retire}, 32'd1);
      end
      chk("t1_instret", instret, 32'd3);
      chk("t1_pc",      pc, 32'hC);

      // Three fetch wait states at pc 0xC
      imem_ready = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("t2_wait_req",  {31'd0, imem_req}, 32'd1);
         chk("t2_wait_addr", imem_addr, 32'hC);
      end
      imem_ready = 1'b1;
      imem_rdata = 32'h0050_0093;
      step();
      chk("t2_instr", instr, 32'h0050_0093);
      imem_rdata = 32'h1111_1111;       // ignored outside FETCH
      step();
      step();
      chk("t2_retire", {31'd0, retire}, 32'd1);
      chk("t2_instr_hold", instr, 32'h0050_0093);

      // Instruction without a register write at pc 0x10
      step();
      chk("t3_pc", pc, 32'h10);
      dec_w_enable = 1'b0;
      imem_rdata   = 32'h0000_0063;
      step();
      step();
      step();
      chk("t3_retire", {31'd0, retire}, 32'd1);
      chk("t3_no_wr",  {31'd0, rf_w_enable}, 32'd0);
      step();
      chk("t3_pc_next", pc, 32'h14);
      dec_w_enable = 1'b1;

      // Asynchronous reset during DECODE
      step();
      chk("t5_in_decode", {31'd0, rf_rd_enable}, 32'd1);
      reset = 1'b0;
      #1;
      chk("t5_req",     {31'd0, imem_req}, 32'd0);
      chk("t5_pc",      pc, 32'h0);
      chk("t5_instr",   instr, 32'h0000_0013);
      chk("t5_instret", instret, 32'd0);
      chk("t5_wr",      {31'd0, rf_w_enable}, 32'd0);
      step();
      step();
      reset = 1'b1;
      step();
      chk("t5_refetch_req",  {31'd0, imem_req}, 32'd1);
      chk("t5_refetch_addr", imem_addr, 32'h0);

      // Halt raised during EXEC of the instruction at pc 0x8
      for (int c = 2; c <= 11; c++) step();
      chk("t4_exec_pc", pc, 32'h8);
      chk("t4_in_exec", {31'd0, rf_rd_enable}, 32'd1);
      halt = 1'b1;
      step();
      chk("t4_retire", {31'd0, retire}, 32'd1);
      step();
      chk("t4_halted", {31'd0, halted}, 32'd1);
      chk("t4_pc",     pc, 32'hC);
      chk("t4_noreq",  {31'd0, imem_req}, 32'd0);
      step();
      step();
      chk("t4_still_halted", {31'd0, halted}, 32'd1);
      halt = 1'b0;
      step();
      chk("t4_resume_req",  {31'd0, imem_req}, 32'd1);
      chk("t4_resume_addr", imem_addr, 32'hC);

      // Halt already asserted when leaving reset parks the core from IDLE
      halt  = 1'b1;
      reset = 1'b0;
      step();
      reset = 1'b1;
      step();
      chk("t6_halted", {31'd0, halted}, 32'd1);
      halt = 1'b0;
      step();
      chk("t6_fetch_addr", imem_addr, 32'h0);

      // PC wraps from 0xFFFF_FFFC to 0
      reset2 = 1'b1;
      step();
      chk("t7_addr", imem_addr2, 32'hFFFF_FFFC);
      begin
         int budget = 20;
         while (!retire2 && budget > 0) begin
            step();
            budget--;
         end
         chk("t7_retire_seen", {31'd0, retire2}, 32'd1);
      end
      step();
      chk("t7_pc_wrap",  pc2, 32'h0);
      chk("t7_instret",  instret2, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
